// File: rtl/imm_builder.sv
// imm_builder: builds an instruction immediate from 2- or 4-bit operand chunks.
// Prefix instructions (ctrl=11) shift chunks into an accumulator. Any other
// valid instruction consumes the accumulator plus its own chunk and produces a
// registered result: a LUT lookup, a sign-extended value or an unsigned value.
//
// Ports
//   clk             rising-edge clock
//   reset_n         synchronous active-low reset
//   in_valid        immediate fields valid this cycle
//   ctrl            00 LUT, 01 sign extend, 10 unsigned, 11 prefix
//   numBits         0: 2-bit chunk (immediateInput1), 1: 4-bit chunk
//   immediateInput0 upper operand field
//   immediateInput1 lower operand field
//   lut_we          LUT write enable (independent of in_valid)
//   lut_waddr       LUT write address
//   lut_wdata       LUT write data
//   out_valid       one-cycle pulse when immediateValue is updated
//   immediateValue  registered result, held until the next result
//   acc_overflow    set when the consumed value was wider than WIDTH bits
module imm_builder #(
  parameter int WIDTH     = 8,
  parameter int LUT_DEPTH = 16,
  parameter int AW        = $clog2(LUT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [1:0]       ctrl,
  input  logic             numBits,
  input  logic [1:0]       immediateInput0,
  input  logic [1:0]       immediateInput1,
  input  logic             lut_we,
  input  logic [AW-1:0]    lut_waddr,
  input  logic [WIDTH-1:0] lut_wdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] immediateValue,
  output logic             acc_overflow
);

  // pre_bits saturates at WIDTH+4; total may add one more 4-bit chunk on top.
  localparam int PBW = $clog2(WIDTH + 5);
  localparam int TW  = PBW + 1;
  localparam logic [PBW-1:0] PB_MAX = PBW'(WIDTH + 4);

  logic [WIDTH-1:0] pre_q, pre_d;
  logic [PBW-1:0]   pre_bits_q, pre_bits_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] lut_q [LUT_DEPTH];

  logic [TW-1:0]    chunk_bits;
  logic [TW-1:0]    total;
  logic [WIDTH-1:0] full;
  logic [AW-1:0]    lut_addr;

  // Saturate the running bit count so long prefix chains cannot wrap it.
  function automatic logic [PBW-1:0] sat_bits(input logic [TW-1:0] t);
    if (t > TW'(PB_MAX)) return PB_MAX;
    return t[PBW-1:0];
  endfunction

  // Bits at and above position n are replaced by bit n-1 (sgn=1) or zero
  // (sgn=0). When n >= WIDTH no bit qualifies, so the value passes unchanged.
  function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] v,
                                              input logic [TW-1:0]    n,
                                              input logic             sgn);
    logic [WIDTH-1:0] r;
    logic             fill;
    r    = v;
    fill = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (TW'(j) + TW'(1) == n) fill = v[j];
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (TW'(i) >= n) r[i] = sgn & fill;
    end
    return r;
  endfunction

  assign chunk_bits = numBits ? TW'(4) : TW'(2);
  assign total      = TW'(pre_bits_q) + chunk_bits;
  assign full       = numBits ? WIDTH'({pre_q, immediateInput0, immediateInput1})
                              : WIDTH'({pre_q, immediateInput1});
  assign lut_addr   = AW'(full);

  always_comb begin
    pre_d      = pre_q;
    pre_bits_d = pre_bits_q;
    imm_d      = imm_q;
    vld_d      = 1'b0;
    ovf_d      = ovf_q;
    if (in_valid) begin
      if (ctrl == 2'b11) begin
        pre_d      = full;
        pre_bits_d = sat_bits(total);
      end else begin
        pre_d      = '0;
        pre_bits_d = '0;
        vld_d      = 1'b1;
        ovf_d      = (total > TW'(WIDTH));
        case (ctrl)
          2'b00:   imm_d = lut_q[lut_addr];
          2'b01:   imm_d = extend(full, total, 1'b1);
          default: imm_d = extend(full, total, 1'b0);
        endcase
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q      <= '0;
      pre_bits_q <= '0;
      imm_q      <= '0;
      vld_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      pre_bits_q <= pre_bits_d;
      imm_q      <= imm_d;
      vld_q      <= vld_d;
      ovf_q      <= ovf_d;
    end
  end

  // LUT storage; a lookup in the same cycle as a write sees the old entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= WIDTH'(i);
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign out_valid      = vld_q;
  assign immediateValue = imm_q;
  assign acc_overflow   = ovf_q;

endmodule

// File: doc/imm_builder.md
IMM_BUILDER -- requirements
Module: imm_builder

Interface
REQ-001 Parameter WIDTH, default 8: immediate output width; SHALL be even and >= 4.
REQ-002 Parameter LUT_DEPTH, default 16: number of LUT entries; SHALL be a power of two >= 16.
REQ-003 Parameter AW, default $clog2(LUT_DEPTH): LUT address width.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  instruction immediate fields valid this cycle.
REQ-007 ctrl  input  2  mode: 00 LUT, 01 sign extend, 10 unsigned, 11 prefix (accumulate).
REQ-008 numBits  input  1  0: 2-bit chunk (immediateInput1); 1: 4-bit chunk {immediateInput0, immediateInput1}.
REQ-009 immediateInput0  input  2  upper operand field.
REQ-010 immediateInput1  input  2  lower operand field.
REQ-011 lut_we  input  1  LUT write enable.
REQ-012 lut_waddr  input  AW  LUT write address.
REQ-013 lut_wdata  input  WIDTH  LUT write data.
REQ-014 out_valid  output  1  one-cycle pulse: immediateValue updated.
REQ-015 immediateValue  output  WIDTH  final immediate, registered.
REQ-016 acc_overflow  output  1  sticky: prefixed value exceeded WIDTH bits.

Function
REQ-017 chunk = numBits ? {immediateInput0, immediateInput1} : {2'b00, immediateInput1}; chunk_bits = numBits ? 4 : 2.
REQ-018 State: prefix register pre (WIDTH bits), bit counter pre_bits (saturating at WIDTH+4), LUT array, output registers.
REQ-019 in_valid=0: no state change; out_valid=0; lut_we still honoured.
REQ-020 ctrl=11 with in_valid: pre <= {pre, chunk[chunk_bits-1:0]} truncated to low WIDTH bits; pre_bits += chunk_bits (saturating); no out_valid.
REQ-021 ctrl!=11 with in_valid: full = {pre, chunk} (low WIDTH bits), total = pre_bits + chunk_bits; pre, pre_bits cleared next cycle.
REQ-022 Unsigned (10): result = full, zero above bit total-1 (when total < WIDTH).
REQ-023 Sign extend (01): result = full with bit total-1 replicated into bits WIDTH-1..total; total >= WIDTH: no extension.
REQ-024 LUT (00): result = LUT[full mod LUT_DEPTH].
REQ-025 Latency: result on immediateValue and out_valid=1 exactly one cycle after the consuming edge; immediateValue holds until next result.
REQ-026 acc_overflow set at the consuming edge when total > WIDTH (high bits discarded, low WIDTH kept); cleared at the next consuming edge with total <= WIDTH.
REQ-027 LUT write occurs at edge when lut_we=1, independent of in_valid; simultaneous read of same address returns old data.
REQ-028 Back-to-back valid instructions every cycle SHALL be accepted with no bubbles.

Reset
REQ-029 reset_n=0 at an edge: immediateValue=0, out_valid=0, acc_overflow=0, pre=0, pre_bits=0, LUT[i]=i (low WIDTH bits); inputs ignored.
REQ-030 Reset mid-prefix discards accumulated prefix; the first instruction after reset sees pre_bits=0.
REQ-031 Reset has priority over lut_we and in_valid in the same cycle.

Verification (WIDTH=8, LUT_DEPTH=16)
REQ-032 ctrl=10, numBits=1, in0=10, in1=11 -> next cycle out_valid=1, immediateValue=0x0B.
REQ-033 ctrl=01, numBits=0, in1=10 -> 0xFE; then ctrl=01, numBits=1, {10,01} -> 0xF9 on consecutive cycles.
REQ-034 ctrl=11 {01,10}, then ctrl=10 {11,01} -> no out_valid after first, 0x6D after second; ctrl=11 {10,00} then ctrl=01 numBits=0 in1=01 -> 0xE1 (6-bit 0x21 sign-extended).
REQ-035 Three ctrl=11 4-bit prefixes 0x1,0x2,0x3 then ctrl=10 chunk 0x4 -> immediateValue=0x34, acc_overflow=1; next ctrl=10 plain -> acc_overflow=0.
REQ-036 After reset, ctrl=00 chunk 3 with lut_we=1, waddr=3, wdata=0xA5 same cycle -> 0x03; repeat next cycle -> 0xA5.
REQ-037 ctrl=11 {11,11}, reset_n=0 one cycle, then ctrl=10 numBits=0 in1=01 -> 0x01, out_valid=0 throughout reset.
